// File: rtl/shot_ctrl_pkg.sv
// shot_ctrl_pkg: state encoding and default timing shared by the shot generator
package shot_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FLIGHT   = 2'b01,
    LAND     = 2'b10,
    COOLDOWN = 2'b11
  } state_t;
  localparam int FLIGHT_CYCLES_DEF   = 8;
  localparam int COOLDOWN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 4;
endpackage

// File: rtl/shot_unit.sv
// shot_unit: one player's fire synchroniser, edge detect, flight/cooldown FSM
// clk: clock; rst_n: async active-low reset; fire: raw button; done: game over
// dp: one-cycle landing pulse; busy: unit not idle
module shot_unit
  import shot_ctrl_pkg::*;
#(
  parameter int FLIGHT_CYCLES   = FLIGHT_CYCLES_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic done,
  output logic dp,
  output logic busy
);
  localparam logic [CNT_W-1:0] FLIGHT_LOAD = CNT_W'(FLIGHT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);
  logic sync1, sync2, prev, req;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  // history flops reset high so a button held through reset never fires
  assign req  = sync2 & ~prev;
  assign dp   = state == LAND;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= fire;
      sync2 <= sync1;
      prev  <= sync2;
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (done) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else
      case (state)
        IDLE:
          if (req) begin
            state_n = FLIGHT;
            cnt_n   = FLIGHT_LOAD;
          end
        FLIGHT:
          if (cnt == '0) state_n = LAND;
          else cnt_n = cnt - 1'b1;
        LAND: begin
          state_n = COOLDOWN;
          cnt_n   = COOL_LOAD;
        end
        default:
          if (cnt == '0) state_n = IDLE;
          else cnt_n = cnt - 1'b1;
      endcase
  end
endmodule

// File: rtl/shot_ctrl.sv
// shot_ctrl: two independent per-player shot units sharing clock and reset
// CLK/RST: clock, async active-low reset; FIRE1/FIRE2: raw buttons; DONE: game over
// DP1/DP2: landing pulses; BUSY1/BUSY2: units not idle
module shot_ctrl
  import shot_ctrl_pkg::*;
#(
  parameter int FLIGHT_CYCLES   = FLIGHT_CYCLES_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic FIRE1,
  input  logic FIRE2,
  input  logic DONE,
  output logic DP1,
  output logic DP2,
  output logic BUSY1,
  output logic BUSY2
);
  shot_unit #(
    .FLIGHT_CYCLES(FLIGHT_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
    .CNT_W(CNT_W)
  ) u_p1 (
    .clk(CLK),
    .rst_n(RST),
    .fire(FIRE1),
    .done(DONE),
    .dp(DP1),
    .busy(BUSY1)
  );
  shot_unit #(
    .FLIGHT_CYCLES(FLIGHT_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
    .CNT_W(CNT_W)
  ) u_p2 (
    .clk(CLK),
    .rst_n(RST),
    .fire(FIRE2),
    .done(DONE),
    .dp(DP2),
    .busy(BUSY2)
  );
endmodule

// File: tb/tb_shot_ctrl.sv
// tb_shot_ctrl: table-driven check of shot_ctrl timing plus reset corner cases
module tb_shot_ctrl;
  logic clk = 1'b0, rst = 1'b0, fire1 = 1'b1, fire2 = 1'b0, done = 1'b0;
  logic dp1, dp2, busy1, busy2;
  int total = 0, bad = 0;
  typedef struct packed {
    logic f1, f2, d, dp1, dp2, b1, b2;
  } vec_t;
  vec_t vq[$];
  shot_ctrl dut (
    .CLK(clk),
    .RST(rst),
    .FIRE1(fire1),
    .FIRE2(fire2),
    .DONE(done),
    .DP1(dp1),
    .DP2(dp2),
    .BUSY1(busy1),
    .BUSY2(busy2)
  );
  always #5 clk = ~clk;
  task automatic add(input logic f1, f2, d, e_dp1, e_dp2, e_b1, e_b2);
    vq.push_back('{f1, f2, d, e_dp1, e_dp2, e_b1, e_b2});
  endtask
  task automatic rel(input int n);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk(input string name, input logic [3:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {dp1,dp2,busy1,busy2}=%b want %b", name, got, exp);
    end
  endtask
  initial begin
    // button held through reset, then 20 cycles held: nothing fires
    for (int k = 0; k < 20; k++) add(1, 0, 0, 0, 0, 0, 0);
    rel(4);
    // single held press: one shot, busy 2..14, land at 10
    for (int k = 0; k < 20; k++) add(1, 0, 0, k == 10, 0, k >= 2 && k <= 14, 0);
    rel(4);
    // re-presses during flight (6) and cooldown (12) dropped; press at 16 fires
    for (int k = 0; k < 34; k++)
      add((k <= 2) || (k >= 6 && k <= 8) || (k >= 12 && k <= 13) || (k >= 16 && k <= 18), 0, 0,
          k == 10 || k == 26, 0, (k >= 2 && k <= 14) || (k >= 18 && k <= 30), 0);
    // simultaneous presses land together
    for (int k = 0; k < 20; k++)
      add(1, 1, 0, k == 10, k == 10, k >= 2 && k <= 14, k >= 2 && k <= 14);
    rel(4);
    // player 2 three cycles behind
    for (int k = 0; k < 22; k++)
      add(1, k >= 3, 0, k == 10, k == 13, k >= 2 && k <= 14, k >= 5 && k <= 17);
    rel(4);
    // DONE aborts flight, blocks a press, then a fresh press fires normally
    for (int k = 0; k < 36; k++)
      add((k <= 7) || (k >= 10 && k <= 11) || (k >= 18), 0, k >= 6 && k <= 15,
          k == 28, 0, (k >= 2 && k <= 5) || (k >= 20 && k <= 32), 0);
    rel(4);
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {dp1, dp2, busy1, busy2}, 4'b0000);
    @(negedge clk) rst = 1'b1;
    foreach (vq[i]) begin
      @(negedge clk);
      fire1 = vq[i].f1;
      fire2 = vq[i].f2;
      done  = vq[i].d;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), {dp1, dp2, busy1, busy2},
             {vq[i].dp1, vq[i].dp2, vq[i].b1, vq[i].b2});
    end
    // async reset in the cycle before landing
    @(negedge clk) fire1 = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("pre_reset_flight", {dp1, dp2, busy1, busy2}, 4'b0010);
    @(negedge clk) rst = 1'b0;
    #1 chk("async_reset", {dp1, dp2, busy1, busy2}, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1 chk($sformatf("post_reset%0d", k), {dp1, dp2, busy1, busy2}, 4'b0000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
